// File: rtl/cla_seq_arb.sv
// Two-requester round-robin adder that runs a WIDTH-bit add one nibble per cycle through an external 4-bit CLA slice.
// Grant to rsp_valid takes NIB+1 cycles; the result holds in DONE until rsp_ready; requesters stall (ready=0) while busy.
module cla_seq_arb #(
  parameter int WIDTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nx;
  logic [WIDTH-1:0] a_sh, b_sh, nib_mask;
  logic [IW-1:0]    idx_q;
  logic             carry_q, id_q, last_q;
  logic             grant, gnt_id, last_nib;

  // Round-robin only matters on a tie; last_q resets to 1 so requester 0 wins first.
  assign grant    = (state == IDLE) && !wb_rst_i && (req0_valid || req1_valid);
  assign gnt_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign last_nib = (idx_q == IW'(NIB - 1));

  assign a_sh     = a_q >> {idx_q, 2'b00};
  assign b_sh     = b_q >> {idx_q, 2'b00};
  assign nib_mask = WIDTH'(4'hF) << {idx_q, 2'b00};
  assign acc_nx   = (acc_q & ~nib_mask) | (WIDTH'(slice_s) << {idx_q, 2'b00});

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = RUN;
      RUN:     if (last_nib) state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant && !gnt_id;
    req1_ready = grant && gnt_id;
    rsp_valid  = (state == DONE);
    slice_a    = 4'h0;
    slice_b    = 4'h0;
    slice_cin  = 1'b0;
    if (state == RUN) begin
      slice_a   = a_sh[3:0];
      slice_b   = b_sh[3:0];
      slice_cin = carry_q;
    end
  end

  // The sum builds up in acc_q so the visible result stays frozen until the last nibble lands.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (grant) begin
      a_q     <= gnt_id ? req1_a : req0_a;
      b_q     <= gnt_id ? req1_b : req0_b;
      carry_q <= gnt_id ? req1_cin : req0_cin;
      idx_q   <= '0;
      id_q    <= gnt_id;
      last_q  <= gnt_id;
    end else if (state == RUN) begin
      acc_q   <= acc_nx;
      carry_q <= slice_cout;
      idx_q   <= idx_q + 1'b1;
      if (last_nib) begin
        rsp_sum  <= acc_nx;
        rsp_cout <= slice_cout;
        rsp_id   <= id_q;
      end
    end
  end

endmodule
